// File: rtl/morra_pkg.sv
// Shared encodings for the morra round scheduler: moves, results, FSM states
// and the move-dominance rule.
package morra_pkg;

  localparam int MIN_ROUNDS = 4;

  typedef enum logic [1:0] {
    MV_NONE    = 2'b00,
    MV_SASSO   = 2'b01,
    MV_CARTA   = 2'b10,
    MV_FORBICE = 2'b11
  } move_e;

  typedef enum logic [1:0] {
    RES_NONE = 2'b00,
    RES_P1   = 2'b01,
    RES_P2   = 2'b10,
    RES_DRAW = 2'b11
  } res_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_COLLECT,
    S_RESOLVE,
    S_EMIT,
    S_DONE
  } state_e;

  typedef struct packed {
    logic  full;
    move_e mv;
  } slot_t;

  // True when move a defeats move b (both assumed non-NONE).
  function automatic logic beats(move_e a, move_e b);
    return (a == MV_SASSO   && b == MV_FORBICE) ||
           (a == MV_FORBICE && b == MV_CARTA)   ||
           (a == MV_CARTA   && b == MV_SASSO);
  endfunction

endpackage

// File: rtl/morra_round_sched_if.sv
// Player offers, result handshake and match status between the scheduler
// (slave) and the game logic driving it (master).
interface morra_round_sched_if;
  logic       start;
  logic [3:0] cfg_extra;
  logic       p1_valid;
  logic [1:0] p1_move;
  logic       p1_ready;
  logic       p2_valid;
  logic [1:0] p2_move;
  logic       p2_ready;
  logic       res_valid;
  logic [1:0] res_winner;
  logic       res_ready;
  logic [4:0] round_idx;
  logic       busy;
  logic       match_done;

  modport master (
    output start, cfg_extra, p1_valid, p1_move, p2_valid, p2_move, res_ready,
    input  p1_ready, p2_ready, res_valid, res_winner, round_idx, busy, match_done
  );

  modport slave (
    input  start, cfg_extra, p1_valid, p1_move, p2_valid, p2_move, res_ready,
    output p1_ready, p2_ready, res_valid, res_winner, round_idx, busy, match_done
  );
endinterface

// File: rtl/morra_judge.sv
// Combinational move-pair judge: void on any missing move, draw on equal moves,
// otherwise the dominating move wins.
module morra_judge
  import morra_pkg::*;
(
  input  move_e mv1,
  input  move_e mv2,
  output res_e  winner
);

  always_comb begin
    winner = RES_NONE;
    if (mv1 == MV_NONE || mv2 == MV_NONE) winner = RES_NONE;
    else if (mv1 == mv2)                  winner = RES_DRAW;
    else if (beats(mv1, mv2))             winner = RES_P1;
    else                                  winner = RES_P2;
  end

endmodule

// File: rtl/morra_round_sched.sv
// Morra match scheduler: collects one move per player per round, judges it
// (with forfeit timeout and repeated-winning-move blocking) and hands results out.
module morra_round_sched
  import morra_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  morra_round_sched_if.slave    bus
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES - 1);

  state_e        state, state_d;
  logic [4:0]    max_rounds, round_idx, idx_inc;
  slot_t         s1, s2;
  move_e         blk1, blk2;
  logic [TW-1:0] timer;
  res_e          win_q, judged, outcome;
  logic          both_full, one_full, forfeit, void_blk;
  logic          take1, take2, p1_rdy, p2_rdy;

  assign both_full = s1.full & s2.full;
  assign one_full  = s1.full ^ s2.full;
  assign forfeit   = !both_full;
  assign idx_inc   = round_idx + {4'd0, win_q != RES_NONE};
  assign take1     = p1_rdy & bus.p1_valid;
  assign take2     = p2_rdy & bus.p2_valid;

  morra_judge u_judge (
    .mv1    (s1.mv),
    .mv2    (s2.mv),
    .winner (judged)
  );

  // Replaying the move that won the last decisive round voids the round.
  assign void_blk = (blk1 != MV_NONE && s1.mv == blk1) ||
                    (blk2 != MV_NONE && s2.mv == blk2);

  always_comb begin
    outcome = RES_NONE;
    if (forfeit)       outcome = s1.full ? RES_P1 : (s2.full ? RES_P2 : RES_NONE);
    else if (void_blk) outcome = RES_NONE;
    else               outcome = judged;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_d;
  end

  always_comb begin
    state_d = state;
    p1_rdy  = 1'b0;
    p2_rdy  = 1'b0;
    case (state)
      S_IDLE:    if (bus.start) state_d = S_COLLECT;
      S_COLLECT: begin
        p1_rdy = !s1.full;
        p2_rdy = !s2.full;
        if (both_full || (one_full && timer == TMAX)) state_d = S_RESOLVE;
      end
      S_RESOLVE: state_d = S_EMIT;
      S_EMIT:    if (bus.res_ready) state_d = (idx_inc == max_rounds) ? S_DONE : S_COLLECT;
      S_DONE:    state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      max_rounds <= '0;
      round_idx  <= '0;
      s1         <= '0;
      s2         <= '0;
      blk1       <= MV_NONE;
      blk2       <= MV_NONE;
      timer      <= '0;
      win_q      <= RES_NONE;
    end else begin
      case (state)
        S_IDLE: if (bus.start) begin
          max_rounds <= 5'(MIN_ROUNDS) + {1'b0, bus.cfg_extra};
          round_idx  <= '0;
          s1         <= '0;
          s2         <= '0;
          blk1       <= MV_NONE;
          blk2       <= MV_NONE;
          timer      <= '0;
          win_q      <= RES_NONE;
        end
        S_COLLECT: begin
          if (take1) s1 <= '{full: 1'b1, mv: move_e'(bus.p1_move)};
          if (take2) s2 <= '{full: 1'b1, mv: move_e'(bus.p2_move)};
          timer <= one_full ? timer + 1'b1 : '0;
        end
        S_RESOLVE: begin
          win_q <= outcome;
          if (forfeit) begin
            blk1 <= MV_NONE;
            blk2 <= MV_NONE;
          end else if (outcome == RES_P1) begin
            blk1 <= s1.mv;
            blk2 <= MV_NONE;
          end else if (outcome == RES_P2) begin
            blk1 <= MV_NONE;
            blk2 <= s2.mv;
          end
        end
        S_EMIT: if (bus.res_ready) begin
          round_idx <= idx_inc;
          s1        <= '0;
          s2        <= '0;
          timer     <= '0;
        end
        default: ;
      endcase
    end
  end

  assign bus.p1_ready   = p1_rdy;
  assign bus.p2_ready   = p2_rdy;
  assign bus.res_valid  = (state == S_EMIT);
  assign bus.res_winner = (state == S_EMIT) ? win_q : RES_NONE;
  assign bus.round_idx  = round_idx;
  assign bus.busy       = (state != S_IDLE);
  assign bus.match_done = (state == S_DONE);

endmodule
